// File: rtl/gba_drawer_vram_arbiter.sv
// gba_drawer_vram_arbiter
//   Shares the single VRAM drawer read port between NREQ background drawers.
//   Round-robin grant with at most one read issued per cycle. Reads return after
//   a fixed LATENCY and are routed back to their requester by a tag pipeline.
//
// Ports
//   fclk          system clock
//   reset         synchronous, active-high reset
//   drawline      line start; resets the round-robin pointer only
//   req           per-requester read request (level)
//   req_addr      packed word addresses, requester i at [i*AW +: AW]
//   vram_rd       read strobe to the VRAM port
//   vram_addr     word address to the VRAM port (holds when idle)
//   vram_data     VRAM read data, valid the cycle after edge grant+LATENCY
//   drawer_valid  one-hot, one-cycle return strobe
//   drawer_data   return data, shared by all requesters; holds between returns
//   busy          a read is being issued or is in flight
module gba_drawer_vram_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 14,
  parameter int DW      = 32,
  parameter int LATENCY = 2
) (
  input  logic               fclk,
  input  logic               reset,
  input  logic               drawline,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic               vram_rd,
  output logic [AW-1:0]      vram_addr,
  input  logic [DW-1:0]      vram_data,
  output logic [NREQ-1:0]    drawer_valid,
  output logic [DW-1:0]      drawer_data,
  output logic               busy
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         pending_reg;
  logic [IW-1:0]           rr_ptr_reg;
  logic                    vram_rd_reg;
  logic [AW-1:0]           vram_addr_reg;
  logic [NREQ-1:0]         drawer_valid_reg;
  logic [DW-1:0]           drawer_data_reg;

  // Tag pipeline has one stage beyond LATENCY: the tag is needed at the edge
  // that captures vram_data, which is one edge after the data appears.
  logic [LATENCY:0]        tag_valid_reg;
  logic [LATENCY:0][IW-1:0] tag_idx_reg;

  logic [AW-1:0]           addr_arr [NREQ];
  logic [NREQ-1:0]         ret_onehot;
  logic [NREQ-1:0]         grant_onehot;
  logic [NREQ-1:0]         eligible;
  logic                    grant_found;
  logic [IW-1:0]           grant_idx;
  logic [IW-1:0]           rr_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]     = req_addr[gi*AW +: AW];
      // Return being launched on this edge; always a subset of pending.
      assign ret_onehot[gi]   = tag_valid_reg[LATENCY] && (tag_idx_reg[LATENCY] == IW'(gi));
      assign grant_onehot[gi] = grant_found && (grant_idx == IW'(gi));
    end
  endgenerate

  // A requester with a read outstanding may not issue another; its pending bit
  // clears on the edge that raises its drawer_valid, so a held req is granted
  // again on the following edge.
  assign eligible = req & ~pending_reg & ~ret_onehot;

  // First eligible requester at or after rr_ptr, searching cyclically.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // drawline wins over the post-grant pointer advance; the grant itself has
  // already used the old pointer.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_found) begin
      if (grant_idx == IW'(NREQ - 1)) rr_ptr_next = '0;
      else                            rr_ptr_next = grant_idx + 1'b1;
    end
    if (drawline) rr_ptr_next = '0;
  end

  always_ff @(posedge fclk) begin
    if (reset) begin
      pending_reg      <= '0;
      rr_ptr_reg       <= '0;
      vram_rd_reg      <= 1'b0;
      vram_addr_reg    <= '0;
      drawer_valid_reg <= '0;
      drawer_data_reg  <= '0;
      tag_valid_reg    <= '0;
      tag_idx_reg      <= '0;
    end else begin
      vram_rd_reg <= grant_found;
      if (grant_found) vram_addr_reg <= addr_arr[grant_idx];

      tag_valid_reg[0] <= grant_found;
      tag_idx_reg[0]   <= grant_idx;
      for (int k = 1; k <= LATENCY; k++) begin
        tag_valid_reg[k] <= tag_valid_reg[k-1];
        tag_idx_reg[k]   <= tag_idx_reg[k-1];
      end

      pending_reg      <= (pending_reg & ~ret_onehot) | grant_onehot;
      drawer_valid_reg <= ret_onehot;
      if (tag_valid_reg[LATENCY]) drawer_data_reg <= vram_data;

      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign vram_rd      = vram_rd_reg;
  assign vram_addr    = vram_addr_reg;
  assign drawer_valid = drawer_valid_reg;
  assign drawer_data  = drawer_data_reg;
  assign busy         = vram_rd_reg | (|pending_reg);

endmodule

// File: tb/tb_gba_drawer_vram_arbiter.sv
// Testbench for gba_drawer_vram_arbiter: directed scenarios followed by random
// request/drawline/reset traffic, checked every cycle against a transaction-level
// reference model (pending set, pointer, queue of in-flight reads with due cycle).
module tb_gba_drawer_vram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int LAT  = 2;

  logic               fclk = 1'b0;
  logic               reset;
  logic               drawline;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic               vram_rd;
  logic [AW-1:0]      vram_addr;
  logic [DW-1:0]      vram_data;
  logic [NREQ-1:0]    drawer_valid;
  logic [DW-1:0]      drawer_data;
  logic               busy;

  gba_drawer_vram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .fclk(fclk), .reset(reset), .drawline(drawline), .req(req), .req_addr(req_addr),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .drawer_valid(drawer_valid), .drawer_data(drawer_data), .busy(busy)
  );

  always #5 fclk = ~fclk;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;

  // ---------------- reference model state ----------------
  typedef struct { int due; int idx; logic [AW-1:0] addr; } rd_t;
  rd_t fly[$];
  logic [NREQ-1:0] m_pend;
  int              m_rr;
  logic            m_rd;
  logic [AW-1:0]   m_addr;
  logic [NREQ-1:0] m_valid;
  logic [DW-1:0]   m_data;

  // ---------------- VRAM model history ----------------
  typedef struct { logic rd; logic [AW-1:0] addr; } hist_t;
  hist_t hist[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ DW'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int g;
    if (reset) begin
      m_pend = '0; m_rr = 0; m_rd = 1'b0; m_addr = '0; m_valid = '0; m_data = '0;
      fly.delete();
      return;
    end
    elig    = req & ~m_pend;
    m_valid = '0;
    if (fly.size() > 0 && fly[0].due == cycle) begin
      m_valid[fly[0].idx] = 1'b1;
      m_data              = mem_word(fly[0].addr);
      m_pend[fly[0].idx]  = 1'b0;
      void'(fly.pop_front());
    end
    m_rd = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      g = (m_rr + k) % NREQ;
      if (!m_rd && elig[g]) begin
        m_rd      = 1'b1;
        m_addr    = req_addr[g*AW +: AW];
        m_pend[g] = 1'b1;
        m_rr      = (g + 1) % NREQ;
        fly.push_back('{due: cycle + LAT + 1, idx: g, addr: req_addr[g*AW +: AW]});
      end
    end
    if (drawline) m_rr = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge fclk);
    #1;
    cycle++;
    chk("vram_rd",      64'(vram_rd),      64'(m_rd));
    chk("vram_addr",    64'(vram_addr),    64'(m_addr));
    chk("drawer_valid", 64'(drawer_valid), 64'(m_valid));
    chk("drawer_data",  64'(drawer_data),  64'(m_data));
    chk("busy",         64'(busy),         64'(m_rd | (|m_pend)));
    $display("cyc %0d rst=%0b dl=%0b req=%b rd=%0b addr=%h valid=%b data=%h busy=%0b",
             cycle, reset, drawline, req, vram_rd, vram_addr, drawer_valid, drawer_data, busy);
    // VRAM: data for a read issued at edge k-LAT is presented after edge k;
    // otherwise drive junk so mistimed captures are visible.
    hist.push_back('{rd: vram_rd, addr: vram_addr});
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    if (hist.size() == LAT + 1 && hist[0].rd) vram_data = mem_word(hist[0].addr);
    else                                      vram_data = DW'($urandom);
  endtask

  task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    req_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; drawline = 1'b0; req = '0; req_addr = '0; vram_data = '0;
    m_pend = '0; m_rr = 0; m_rd = 1'b0; m_addr = '0; m_valid = '0; m_data = '0;
    step(); step();
    reset = 1'b0;

    // 1: single request, fixed latency
    set_addrs(14'h0123, 14'h0456, 14'h0789, 14'h0abc);
    req = 4'b0001;
    step();
    chk("t1_rd", 64'(vram_rd), 64'd1);
    chk("t1_addr", 64'(vram_addr), 64'h0123);
    req = 4'b0000;
    step(); step(); step();
    chk("t1_valid", 64'(drawer_valid), 64'b0001);
    chk("t1_data", 64'(drawer_data), 64'(mem_word(14'h0123)));
    idle(2);

    // 2: all requesting, round-robin order
    set_addrs(14'h0010, 14'h0020, 14'h0030, 14'h0040);
    req = 4'b1111;
    for (int i = 0; i < 12; i++) step();
    idle(5);

    // 3: one requester holding req continuously
    req = 4'b0001;
    for (int i = 0; i < 13; i++) begin
      set_addrs(AW'($urandom), 14'h0, 14'h0, 14'h0);
      step();
    end
    idle(5);

    // 4: pointer at 2, then drawline with two requesters
    req = 4'b0010; step();
    idle(5);
    drawline = 1'b1; req = 4'b0011; step();
    drawline = 1'b0; req = 4'b0000;
    chk("t4_addr_req0", 64'(vram_addr), 64'(req_addr[0 +: AW]));
    idle(6);

    // 5: request dropped while pending
    set_addrs(14'h1111, 14'h2222, 14'h3333, 14'h0444);
    req = 4'b0010; step();
    idle(6);

    // 6: reset one cycle after a grant
    req = 4'b0001; step();
    req = 4'b0000; reset = 1'b1; step();
    reset = 1'b0;
    idle(4);
    req = 4'b0001; set_addrs(14'h3abc, 14'h0, 14'h0, 14'h0); step();
    req = 4'b0000;
    idle(5);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      req_addr = (NREQ*AW)'({$urandom, $urandom});
      drawline = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; drawline = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
